// File: rtl/iq_decimator_if.sv
// ----------------------------------------------------------------------------
// iq_decimator_if
//   Sample/result bundle for the I/Q accumulate-and-dump decimator.
//
//   Signals:
//     rx         acquisition window (high = accumulate)
//     log2_r     log2 of decimation ratio, sampled on the rx rising edge
//     in_i/in_q  signed mixed samples, one per clock
//     out_i/q    signed decimated samples, held between strobes
//     out_valid  one-cycle strobe marking a new out_i/out_q
//     frame_cnt  outputs emitted since the last rx rise (wraps)
//
//   Modports:
//     master  sample source / result consumer (mixer + readout side)
//     slave   the decimator itself
// ----------------------------------------------------------------------------
interface iq_decimator_if #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int LR_W  = 4
);
    logic                     rx;
    logic        [LR_W-1:0]   log2_r;
    logic signed [IN_W-1:0]   in_i;
    logic signed [IN_W-1:0]   in_q;
    logic signed [OUT_W-1:0]  out_i;
    logic signed [OUT_W-1:0]  out_q;
    logic                     out_valid;
    logic        [15:0]       frame_cnt;

    modport master (
        output rx, log2_r, in_i, in_q,
        input  out_i, out_q, out_valid, frame_cnt
    );

    modport slave (
        input  rx, log2_r, in_i, in_q,
        output out_i, out_q, out_valid, frame_cnt
    );
endinterface

// File: rtl/iq_decimator.sv
// ----------------------------------------------------------------------------
// iq_decimator
//   I/Q accumulate-and-dump decimator. While rx is high, sums 2^lr
//   consecutive samples per channel and emits one scaled OUT_W-bit average
//   per block, with a one-cycle valid strobe and a frame counter.
//
//   Ports:
//     clk_8x   sole clock, rising edge
//     rst      synchronous, active-high reset
//     bus      iq_decimator_if.slave (rx, log2_r, in_i/q -> out_i/q,
//              out_valid, frame_cnt)
//
//   Build option:
//     IQ_DECIM_ROUND_EN  when defined, round half up before the final shift
//                        and saturate positive overflow; otherwise plain
//                        arithmetic-shift truncation.
// ----------------------------------------------------------------------------
module iq_decimator #(
    parameter int IN_W       = 24,
    parameter int OUT_W      = 16,
    parameter int MAX_LOG2_R = 10,
    parameter int LR_W       = 4
) (
    input  logic            clk_8x,
    input  logic            rst,
    iq_decimator_if.slave   bus
);

    localparam int ACC_W = IN_W + MAX_LOG2_R;

    localparam logic [MAX_LOG2_R:0] CNT_ONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc_i;
    logic signed [ACC_W-1:0]  acc_q;
    logic [MAX_LOG2_R-1:0]    cnt;
    logic [LR_W-1:0]          lr;

    logic signed [OUT_W-1:0]  out_i_p1;
    logic signed [OUT_W-1:0]  out_q_p1;
    logic                     vld_p1;
    logic [15:0]              frame_cnt_p1;

    logic [LR_W-1:0]          lr_eff_p0;
    logic signed [ACC_W-1:0]  sum_i_p0;
    logic signed [ACC_W-1:0]  sum_q_p0;
    logic                     last_p0;

    function automatic logic [LR_W-1:0] clamp_lr(input logic [LR_W-1:0] v);
        if (v > LR_W'(MAX_LOG2_R))
            return LR_W'(MAX_LOG2_R);
        return v;
    endfunction

    // Count value of the final sample in a block of 2^l samples.
    function automatic logic [MAX_LOG2_R-1:0] blk_last(input logic [LR_W-1:0] l);
        logic [MAX_LOG2_R:0] m;
        m = (CNT_ONE << l) - CNT_ONE;
        return m[MAX_LOG2_R-1:0];
    endfunction

    // Divide the block sum by 2^l and drop the extra input precision.
`ifdef IQ_DECIM_ROUND_EN
    localparam logic signed [ACC_W:0] RND_ONE = 1;
    localparam logic signed [ACC_W:0] SAT_HI  = (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);

    function automatic logic signed [OUT_W-1:0] scale(
        input logic signed [ACC_W-1:0] sum,
        input logic [LR_W-1:0]         l
    );
        int                      s;
        logic signed [ACC_W:0]   ext;
        logic signed [ACC_W:0]   half;
        logic signed [ACC_W:0]   sh;
        s    = int'(l) + (IN_W - OUT_W);
        ext  = {sum[ACC_W-1], sum};
        half = (s > 0) ? (RND_ONE <<< (s - 1)) : '0;
        sh   = (ext + half) >>> s;
        // Rounding only ever adds, so only the positive rail can be crossed.
        if (sh > SAT_HI)
            return SAT_HI[OUT_W-1:0];
        return sh[OUT_W-1:0];
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] scale(
        input logic signed [ACC_W-1:0] sum,
        input logic [LR_W-1:0]         l
    );
        int                      s;
        logic signed [ACC_W-1:0] sh;
        s  = int'(l) + (IN_W - OUT_W);
        sh = sum >>> s;
        return sh[OUT_W-1:0];
    endfunction
`endif

    // ---- stage p0: block sum and end-of-block detect ----
    always_comb begin
        lr_eff_p0 = lr;
        if (state == IDLE)
            lr_eff_p0 = clamp_lr(bus.log2_r);
        // cnt==0 starts a block, so the previous block's total is dropped.
        // In IDLE cnt is held at 0, which makes the rx-rise sample sample 0.
        sum_i_p0 = ((state == ACC && cnt != '0) ? acc_i : '0)
                 + {{MAX_LOG2_R{bus.in_i[IN_W-1]}}, bus.in_i};
        sum_q_p0 = ((state == ACC && cnt != '0) ? acc_q : '0)
                 + {{MAX_LOG2_R{bus.in_q[IN_W-1]}}, bus.in_q};
        last_p0  = (cnt == blk_last(lr_eff_p0));
    end

    // ---- stage p1: FSM, accumulators and registered outputs ----
    always_ff @(posedge clk_8x) begin
        if (rst) begin
            state        <= IDLE;
            acc_i        <= '0;
            acc_q        <= '0;
            cnt          <= '0;
            lr           <= '0;
            out_i_p1     <= '0;
            out_q_p1     <= '0;
            vld_p1       <= 1'b0;
            frame_cnt_p1 <= '0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rx) begin
                        lr    <= lr_eff_p0;
                        acc_i <= sum_i_p0;
                        acc_q <= sum_q_p0;
                        state <= ACC;
                        if (last_p0) begin
                            // R=1: the rx-rise sample is a complete block.
                            out_i_p1     <= scale(sum_i_p0, lr_eff_p0);
                            out_q_p1     <= scale(sum_q_p0, lr_eff_p0);
                            vld_p1       <= 1'b1;
                            cnt          <= '0;
                            frame_cnt_p1 <= 16'd1;
                        end else begin
                            cnt          <= MAX_LOG2_R'(1);
                            frame_cnt_p1 <= 16'd0;
                        end
                    end else begin
                        acc_i <= '0;
                        acc_q <= '0;
                        cnt   <= '0;
                    end
                end
                ACC: begin
                    if (bus.rx) begin
                        acc_i <= sum_i_p0;
                        acc_q <= sum_q_p0;
                        if (last_p0) begin
                            out_i_p1     <= scale(sum_i_p0, lr);
                            out_q_p1     <= scale(sum_q_p0, lr);
                            vld_p1       <= 1'b1;
                            cnt          <= '0;
                            frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
                        end else begin
                            cnt <= cnt + MAX_LOG2_R'(1);
                        end
                    end else begin
                        // Window closed: the partial block is thrown away.
                        state <= IDLE;
                        acc_i <= '0;
                        acc_q <= '0;
                        cnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_i     = out_i_p1;
    assign bus.out_q     = out_q_p1;
    assign bus.out_valid = vld_p1;
    assign bus.frame_cnt = frame_cnt_p1;

endmodule

// File: tb/tb_iq_decimator.sv
// ----------------------------------------------------------------------------
// tb_iq_decimator
//   Directed-vector bench for iq_decimator (IN_W=24, OUT_W=16). Expected
//   values are hand-computed; the rounding cases select their expectations
//   from IQ_DECIM_ROUND_EN so the bench fits either build.
// ----------------------------------------------------------------------------
module tb_iq_decimator;

    localparam int IN_W       = 24;
    localparam int OUT_W      = 16;
    localparam int MAX_LOG2_R = 10;
    localparam int LR_W       = 4;

`ifdef IQ_DECIM_ROUND_EN
    localparam logic [31:0] EXP_RND_POS = 32'h0001;
    localparam logic [31:0] EXP_RND_NEG = 32'h0000;
`else
    localparam logic [31:0] EXP_RND_POS = 32'h0000;
    localparam logic [31:0] EXP_RND_NEG = 32'hFFFF;
`endif

    logic clk_8x = 1'b0;
    logic rst    = 1'b1;

    always #5 clk_8x = ~clk_8x;

    iq_decimator_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LR_W(LR_W)) bus ();

    iq_decimator #(
        .IN_W       (IN_W),
        .OUT_W      (OUT_W),
        .MAX_LOG2_R (MAX_LOG2_R),
        .LR_W       (LR_W)
    ) dut (
        .clk_8x (clk_8x),
        .rst    (rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_8x);
        #1;
    endtask

    task automatic drive(input logic r, input logic [LR_W-1:0] l,
                         input logic [IN_W-1:0] i, input logic [IN_W-1:0] q);
        bus.rx     = r;
        bus.log2_r = l;
        bus.in_i   = i;
        bus.in_q   = q;
    endtask

    function automatic logic [31:0] vld();
        return {31'h0, bus.out_valid};
    endfunction

    function automatic logic [31:0] oi();
        return {16'h0, bus.out_i};
    endfunction

    function automatic logic [31:0] oq();
        return {16'h0, bus.out_q};
    endfunction

    function automatic logic [31:0] fc();
        return {16'h0, bus.frame_cnt};
    endfunction

    initial begin
        int nv;

        // Reset state
        drive(1'b0, '0, '0, '0);
        rst = 1'b1;
        tick();
        tick();
        chk("rst_vld",   vld(), 32'h0);
        chk("rst_out_i", oi(),  32'h0);
        chk("rst_out_q", oq(),  32'h0);
        chk("rst_frame", fc(),  32'h0);
        rst = 1'b0;

        // R=4 constant input: strobe on every 4th edge, average = input >> 8
        drive(1'b1, 4'd2, 24'h123400, 24'hEDCC00);
        for (int t = 0; t < 16; t++) begin
            tick();
            chk("r4_vld", vld(), {31'h0, (t % 4) == 3});
            if ((t % 4) == 3) begin
                chk("r4_out_i", oi(), 32'h1234);
                chk("r4_out_q", oq(), 32'hEDCC);
                chk("r4_frame", fc(), 32'(t / 4 + 1));
            end
        end
        drive(1'b0, 4'd2, 24'h123400, 24'hEDCC00);
        tick();
        chk("r4_stop_vld", vld(), 32'h0);

        // R=1 rounding behaviour on a half-LSB and on -1
        drive(1'b1, 4'd0, 24'h000080, 24'hFFFFFF);
        tick();
        chk("rnd_vld",   vld(), 32'h1);
        chk("rnd_pos",   oi(),  EXP_RND_POS);
        chk("rnd_neg",   oq(),  EXP_RND_NEG);
        chk("rnd_frame", fc(),  32'h1);
        drive(1'b0, 4'd0, 24'h0, 24'h0);
        tick();

        // R=8 full-scale: positive rail must not wrap; negative rail exact
        drive(1'b1, 4'd3, 24'h7FFFFF, 24'h800000);
        for (int t = 0; t < 8; t++) begin
            tick();
            chk("fs_vld", vld(), {31'h0, t == 7});
        end
        chk("fs_out_i", oi(), 32'h7FFF);
        chk("fs_out_q", oq(), 32'h8000);
        drive(1'b0, 4'd3, 24'h0, 24'h0);
        tick();

        // Partial block discarded when rx drops on its completing cycle
        drive(1'b1, 4'd2, 24'h000100, 24'h0);
        tick();
        chk("abort_frame_clr", fc(), 32'h0);
        for (int t = 0; t < 2; t++) begin
            tick();
            chk("abort_vld", vld(), 32'h0);
        end
        drive(1'b0, 4'd2, 24'h000100, 24'h0);
        tick();
        chk("abort_fall_vld", vld(), 32'h0);
        chk("abort_hold_i",   oi(),  32'h7FFF);

        // Restart with R=2; later log2_r changes must be ignored
        for (int t = 0; t < 6; t++) begin
            drive(1'b1, (t == 0) ? 4'd1 : 4'd3,
                  (t % 2 == 0) ? 24'h000200 : 24'h000400, 24'h0);
            tick();
            chk("r2_vld", vld(), {31'h0, (t % 2) == 1});
            if ((t % 2) == 1) begin
                chk("r2_out_i", oi(), 32'h3);
                chk("r2_frame", fc(), 32'((t + 1) / 2));
            end
        end
        drive(1'b0, 4'd1, 24'h0, 24'h0);
        tick();

        // Reset mid-block, then restart with rx held high
        drive(1'b1, 4'd3, 24'h000800, 24'h000800);
        for (int t = 0; t < 5; t++) tick();
        rst = 1'b1;
        tick();
        chk("mrst_vld",   vld(), 32'h0);
        chk("mrst_out_i", oi(),  32'h0);
        chk("mrst_out_q", oq(),  32'h0);
        chk("mrst_frame", fc(),  32'h0);
        rst = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk("mrst_re_vld", vld(), {31'h0, t == 7});
        end
        chk("mrst_re_out_i", oi(), 32'h8);
        chk("mrst_re_frame", fc(), 32'h1);
        drive(1'b0, 4'd3, 24'h0, 24'h0);
        tick();

        // log2_r above the maximum clamps to R=1024
        drive(1'b1, 4'd15, 24'h000400, 24'hFFFC00);
        nv = 0;
        for (int t = 0; t < 1023; t++) begin
            tick();
            if (bus.out_valid) nv++;
        end
        chk("clamp_early", 32'(nv), 32'h0);
        tick();
        chk("clamp_vld",   vld(), 32'h1);
        chk("clamp_out_i", oi(),  32'h4);
        chk("clamp_out_q", oq(),  32'hFFFC);
        drive(1'b0, 4'd15, 24'h0, 24'h0);
        tick();

        // frame_cnt wraps after 65536 R=1 outputs
        drive(1'b1, 4'd0, 24'h000100, 24'h0);
        for (int i = 0; i < 65536; i++) begin
            tick();
            if (i == 0)     chk("wrap_first", fc(), 32'h1);
            if (i == 65534) chk("wrap_ffff",  fc(), 32'hFFFF);
            if (i == 65535) begin
                chk("wrap_zero",  fc(),  32'h0);
                chk("wrap_vld",   vld(), 32'h1);
                chk("wrap_out_i", oi(),  32'h1);
            end
        end
        drive(1'b0, 4'd0, 24'h0, 24'h0);
        tick();
        chk("end_vld", vld(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iq_decimator.md
# iq_decimator

Parametrised I/Q accumulate-and-dump decimator: the next generation of the receiver's downsampling stage. Sits between the DDS mixer outputs (`clk_8x` domain) and the acquisition/readout logic. Sums 2^`log2_r` consecutive mixed I and Q samples while `rx` is high and emits one scaled `OUT_W`-bit average per block. Adds a valid strobe, a run-time ratio, an output frame counter and optional rounding/saturation.

## Interface
Parameters:
- `IN_W`, 24, signed width of mixed I/Q input samples.
- `OUT_W`, 16, signed width of decimated outputs; must satisfy `OUT_W` <= `IN_W`.
- `MAX_LOG2_R`, 10, largest supported log2 decimation ratio (R max 1024).
- `LR_W`, 4, width of `log2_r`; must satisfy `LR_W` >= clog2(`MAX_LOG2_R`+1).

Ports:
- `clk_8x`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  acquisition window; high = accumulate, low = idle/discard.
- `log2_r`  in  `LR_W`  log2 of decimation ratio R; sampled only on the `rx` rising edge; values > `MAX_LOG2_R` clamp to `MAX_LOG2_R`.
- `in_i`, `in_q`  in  `IN_W`  signed mixed samples, one per cycle.
- `out_i`, `out_q`  out  `OUT_W`  signed decimated samples; hold between strobes.
- `out_valid`  out  1  one-cycle strobe, new `out_i`/`out_q`.
- `frame_cnt`  out  16  outputs emitted since the last `rx` rise; wraps 0xFFFF->0x0000.

## Operation
- Internal: accumulators `acc_i`/`acc_q`, `IN_W`+`MAX_LOG2_R` bits signed; block counter `cnt`, `MAX_LOG2_R` bits; latched ratio `lr`.
- FSM states: IDLE, ACC.
- IDLE: accumulators and `cnt` held at 0. When `rx`=1:
  - latch `lr` = min(`log2_r`, `MAX_LOG2_R`);
  - clear `frame_cnt`;
  - treat this cycle's input as sample 0 of block 0;
  - go to ACC.
- ACC with `rx`=1:
  - `sum` = (`cnt`==0 ? 0 : `acc`) + sign-extended input;
  - `acc` <= `sum`.
  - If `cnt` == 2^`lr`-1: emit from `sum`, `cnt` <= 0, `frame_cnt` += 1.
  - Otherwise `cnt` += 1.
  - Blocks are back-to-back with no gap cycles.
- Scaling: shift s = `lr` + (`IN_W`-`OUT_W`). Output is `sum` >>> s (arithmetic), low `OUT_W` bits. The accumulator is sized exactly, so no overflow is possible without rounding.
- `rx` low in ACC: the partial block is discarded with no strobe; go to IDLE next cycle. `rx` re-rising starts a fresh block with a newly latched `lr`.
- Changes to `log2_r` while in ACC are ignored.
- `lr`=0 with `IN_W`=`OUT_W`: pure pass-through register, strobe every cycle.
- `rst`: overrides all inputs.
  - State -> IDLE.
  - `acc`, `cnt`, `lr`, `out_i`, `out_q`, `frame_cnt` -> 0.
  - `out_valid` -> 0.
  - A block in progress is lost.

## Timing
- The sample presented on the rx-rise cycle c0 is the first sample of block 0.
- Block k completes on cycle c0 + (k+1)·R − 1. `out_valid` is high on cycle c0 + (k+1)·R (one register stage).
- Latency from the last sample of a block to the strobe: 1 cycle.
- Strobe period: R cycles; R=1 gives a strobe every cycle while `rx`=1.
- `frame_cnt` updates on the same edge as `out_i`/`out_q` and `out_valid`.
- The `rx` falling edge on the same cycle a block would complete: that cycle's sample is not accumulated and no strobe is issued. The FSM samples `rx` before accumulating.
- `rst` and `rx` rise on the same cycle: reset wins; acquisition begins on the next cycle `rx` is seen high.

## Configuration
- `IQ_DECIM_ROUND_EN` defined:
  - when s>0, add 2^(s−1) to `sum` before shifting (round half up);
  - a result above 2^(`OUT_W`−1)−1 saturates to that value;
  - the adder is one bit wider than `acc`.
- `IQ_DECIM_ROUND_EN` undefined: plain truncation toward −infinity, no saturation logic.

## Test plan
All cases use `IN_W`=24, `OUT_W`=16.
- Constant `in_i`=0x123400, `in_q`=0xEDCC00, `log2_r`=2, `rx` high for 16 cycles -> 4 strobes spaced 4 cycles apart; first strobe 4 cycles after the rx rise; `out_i`=0x1234, `out_q`=0xEDCC; `frame_cnt` ends at 4.
- `log2_r`=0, `in_i`=0x000080 -> with `IQ_DECIM_ROUND_EN`: 0x0001; without: 0x0000. `in_i`=0xFFFFFF -> with: 0x0000; without: 0xFFFF.
- `IQ_DECIM_ROUND_EN`, `log2_r`=3, `in_i`=0x7FFFFF constant -> `out_i`=0x7FFF (saturated), no wrap to negative.
- `log2_r`=2, `rx` high 3 cycles then low -> no strobe; `rx` high again with `log2_r`=1 -> strobes every 2 cycles; `frame_cnt` restarts from 0.
- `rst` pulsed mid-block (`log2_r`=3, after 5 samples) -> all outputs 0 the next cycle and no strobe. After `rst` releases with `rx` held high, the first strobe comes 8 cycles after acquisition restarts.
- `log2_r`=15 (>`MAX_LOG2_R`) -> behaves as R=1024. Run 65536 blocks with R=1 -> `frame_cnt` wraps 0xFFFF->0x0000.
